// File: rtl/ou_env_pkg.sv
// ou_env_pkg: Q14 constants, LFSR helpers and FSM encoding for the OU envelope bank
package ou_env_pkg;
   localparam int ENV_MEAN_Q14 = 16384;
   localparam int ENV_LO_Q14 = 8192;
   localparam int ENV_HI_Q14 = 24576;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] ZERO_SEED_SUB = 16'hACE1;
   localparam logic [15:0] COMMON_SEED_XOR = 16'h5A5A;
   localparam logic [15:0] CH_SEED_MUL = 16'h9E37;
   typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_e;
   function automatic logic [15:0] lfsr_next(input logic [15:0] x);
      return {x[14:0], ^(x & LFSR_TAPS)};
   endfunction
   function automatic logic [15:0] seed_fix(input logic [15:0] x);
      return x == 16'h0 ? ZERO_SEED_SUB : x;
   endfunction
endpackage

// File: rtl/ou_env_step.sv
// ou_env_step: combinational single-channel OU step with noise mixing and clamping
module ou_env_step
   import ou_env_pkg::*;
#(
   parameter int WIDTH = 18,
   parameter int FRAC = 14,
   parameter int ENV_MEAN = ENV_MEAN_Q14
) (
   input  logic signed [WIDTH-1:0] work,
   input  logic signed [WIDTH-1:0] tau_inv,
   input  logic signed [WIDTH-1:0] sigma,
   input  logic signed [WIDTH-1:0] env_min,
   input  logic signed [WIDTH-1:0] env_max,
   input  logic        [8:0]       coupling,
   input  logic        [15:0]      lfsr_c,
   input  logic        [15:0]      lfsr_p,
   output logic signed [WIDTH-1:0] nxt
);
   localparam int XW = 2*WIDTH+10;
   localparam logic signed [XW-1:0] K256 = 256;
   localparam logic signed [XW-1:0] K1 = 1;
   function automatic logic signed [XW-1:0] nval(input logic [15:0] x);
      logic signed [XW-1:0] m;
      m = {{(XW-8){1'b0}}, x[7:0]};
      return x[15] ? -m : m;
   endfunction
   logic signed [XW-1:0] cpl, mix, noise, tau, rev, raw, w, hi, lo, c1;
   always_comb begin
      cpl = coupling > 9'd256 ? K256 : XW'(coupling);
      w = XW'(work);
      mix = (nval(lfsr_c) * cpl + nval(lfsr_p) * (K256 - cpl)) >>> 8;
      noise = (mix * XW'(sigma)) >>> 7;
      tau = (tau_inv[WIDTH-1] || tau_inv == '0) ? K1 : XW'(tau_inv);
      rev = (tau * (XW'(ENV_MEAN) - w)) >>> FRAC;
      raw = w + rev + noise;
      hi = XW'(env_max);
      lo = XW'(env_min);
      c1 = raw > hi ? hi : raw;
      nxt = WIDTH'(c1 < lo ? lo : c1);
   end
endmodule

// File: rtl/ou_envelope_bank.sv
// ou_envelope_bank: time-multiplexed multi-channel OU envelope generator with double-buffered output
module ou_envelope_bank
   import ou_env_pkg::*;
#(
   parameter int N_CH = 8,
   parameter int WIDTH = 18,
   parameter int FRAC = 14,
   parameter int DECIM_LOG2 = 4,
   parameter int ENV_MEAN = ENV_MEAN_Q14
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clk_en,
   input  logic [15:0]             seed,
   input  logic signed [WIDTH-1:0] tau_inv,
   input  logic signed [WIDTH-1:0] sigma,
   input  logic [8:0]              coupling,
   input  logic signed [WIDTH-1:0] env_min,
   input  logic signed [WIDTH-1:0] env_max,
   output logic [N_CH*WIDTH-1:0]   env_flat,
   output logic                    env_valid,
   output logic                    busy,
   output logic                    overrun
);
   localparam int CW = $clog2(N_CH);
   localparam int DW = DECIM_LOG2 > 0 ? DECIM_LOG2 : 1;
   state_e state_q, state_d;
   logic [CW-1:0] ch_q, ch_d;
   logic [DW-1:0] decim_q, decim_d;
   logic signed [WIDTH-1:0] work_q [N_CH], work_d [N_CH], out_q [N_CH], out_d [N_CH];
   logic [15:0] lfsr_p_q [N_CH], lfsr_p_d [N_CH];
   logic [15:0] lfsr_c_q, lfsr_c_d, snap_q, snap_d;
   logic signed [WIDTH-1:0] tau_q, tau_d, sigma_q, sigma_d, min_q, min_d, max_q, max_d;
   logic [8:0] cpl_q, cpl_d;
   logic env_valid_q, env_valid_d, busy_q, busy_d, overrun_q, overrun_d;
   logic trig;
   logic signed [WIDTH-1:0] step_out;
   ou_env_step #(.WIDTH(WIDTH), .FRAC(FRAC), .ENV_MEAN(ENV_MEAN)) u_step (
      .work(work_q[ch_q]),
      .tau_inv(tau_q),
      .sigma(sigma_q),
      .env_min(min_q),
      .env_max(max_q),
      .coupling(cpl_q),
      .lfsr_c(snap_q),
      .lfsr_p(lfsr_p_q[ch_q]),
      .nxt(step_out)
   );
   always_comb begin
      trig = clk_en && (DECIM_LOG2 == 0 || decim_q == '0);
      decim_d = DECIM_LOG2 == 0 ? '0 : decim_q + DW'(clk_en);
      state_d = state_q;
      ch_d = ch_q;
      work_d = work_q;
      out_d = out_q;
      lfsr_p_d = lfsr_p_q;
      lfsr_c_d = lfsr_c_q;
      snap_d = snap_q;
      tau_d = tau_q;
      sigma_d = sigma_q;
      min_d = min_q;
      max_d = max_q;
      cpl_d = cpl_q;
      env_valid_d = 1'b0;
      overrun_d = overrun_q | (trig && state_q == ST_SWEEP);
      if (state_q == ST_SWEEP) begin
         work_d[ch_q] = step_out;
         lfsr_p_d[ch_q] = lfsr_next(lfsr_p_q[ch_q]);
         lfsr_c_d = ch_q == '0 ? lfsr_next(lfsr_c_q) : lfsr_c_q;
         ch_d = ch_q + CW'(1);
         state_d = ch_q == CW'(N_CH-1) ? ST_DONE : ST_SWEEP;
      end
      if (state_q == ST_DONE) begin
         out_d = work_q;
         env_valid_d = 1'b1;
         state_d = ST_IDLE;
      end
      // the common noise sample is frozen per sweep so every channel sees the same pre-advance value
      if (trig && state_q != ST_SWEEP) begin
         state_d = ST_SWEEP;
         ch_d = '0;
         snap_d = lfsr_c_q;
         tau_d = tau_inv;
         sigma_d = sigma;
         min_d = env_min;
         max_d = env_max;
         cpl_d = coupling;
      end
      busy_d = state_d == ST_SWEEP;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ch_q <= '0;
         decim_q <= '0;
         for (int k = 0; k < N_CH; k++) begin
            work_q[k] <= WIDTH'(ENV_MEAN);
            out_q[k] <= WIDTH'(ENV_MEAN);
            lfsr_p_q[k] <= seed_fix(seed ^ 16'(k * CH_SEED_MUL));
         end
         lfsr_c_q <= seed_fix(seed ^ COMMON_SEED_XOR);
         snap_q <= seed_fix(seed ^ COMMON_SEED_XOR);
         tau_q <= '0;
         sigma_q <= '0;
         min_q <= '0;
         max_q <= '0;
         cpl_q <= '0;
         env_valid_q <= 1'b0;
         busy_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q <= ch_d;
         decim_q <= decim_d;
         work_q <= work_d;
         out_q <= out_d;
         lfsr_p_q <= lfsr_p_d;
         lfsr_c_q <= lfsr_c_d;
         snap_q <= snap_d;
         tau_q <= tau_d;
         sigma_q <= sigma_d;
         min_q <= min_d;
         max_q <= max_d;
         cpl_q <= cpl_d;
         env_valid_q <= env_valid_d;
         busy_q <= busy_d;
         overrun_q <= overrun_d;
      end
   end
   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign env_flat[g*WIDTH +: WIDTH] = out_q[g];
   end
   assign env_valid = env_valid_q;
   assign busy = busy_q;
   assign overrun = overrun_q;
endmodule

// File: tb/tb_ou_envelope_bank.sv
// tb_ou_envelope_bank: scoreboard bench comparing the envelope bank against a bit-exact reference model
module tb_ou_envelope_bank;
   import ou_env_pkg::*;
   localparam int N = 8;
   localparam int W = 18;
   localparam int F = 14;
   localparam longint M = 16384;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clk_en = 1'b0;
   logic clk_en_d = 1'b0;
   logic [15:0] seed = 16'h1234;
   logic signed [W-1:0] tau_inv = 1;
   logic signed [W-1:0] sigma = 0;
   logic signed [W-1:0] env_min = W'(ENV_LO_Q14);
   logic signed [W-1:0] env_max = W'(ENV_HI_Q14);
   logic [8:0] coupling = 9'd0;
   logic [N*W-1:0] env_flat, env_flat_d;
   logic env_valid, busy, overrun, env_valid_d, busy_d, overrun_d;
   always #5 clk = ~clk;
   ou_envelope_bank #(.N_CH(N), .WIDTH(W), .FRAC(F), .DECIM_LOG2(0), .ENV_MEAN(16384)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .seed(seed), .tau_inv(tau_inv), .sigma(sigma),
      .coupling(coupling), .env_min(env_min), .env_max(env_max), .env_flat(env_flat),
      .env_valid(env_valid), .busy(busy), .overrun(overrun)
   );
   ou_envelope_bank #(.N_CH(N), .WIDTH(W), .FRAC(F), .DECIM_LOG2(4), .ENV_MEAN(16384)) dut_d (
      .clk(clk), .rst(rst), .clk_en(clk_en_d), .seed(seed), .tau_inv(tau_inv), .sigma(sigma),
      .coupling(coupling), .env_min(env_min), .env_max(env_max), .env_flat(env_flat_d),
      .env_valid(env_valid_d), .busy(busy_d), .overrun(overrun_d)
   );
   int errors = 0;
   int checks = 0;
   task automatic check(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask
   function automatic longint lane(input logic [N*W-1:0] v, input int k);
      logic signed [W-1:0] x;
      x = v[k*W +: W];
      return longint'(x);
   endfunction
   function automatic logic [15:0] nx(input logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction
   function automatic logic [15:0] fix(input logic [15:0] x);
      return x == 16'h0 ? 16'hACE1 : x;
   endfunction
   function automatic longint nval(input logic [15:0] x);
      longint m;
      m = longint'(x[7:0]);
      return x[15] ? -m : m;
   endfunction
   longint mw [N];
   logic [15:0] mlc;
   logic [15:0] mlp [N];
   logic [N*W-1:0] exp_q [$];
   longint due_q [$];
   longint cyc = 0;
   longint last = -1000;
   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         mw[k] = M;
         mlp[k] = fix(seed ^ 16'(k * 40503));
      end
      mlc = fix(seed ^ 16'h5A5A);
      exp_q.delete();
      due_q.delete();
      last = -1000;
   endtask
   task automatic model_trigger(input longint e);
      longint t, c, nc, np, mix, noise, rev, raw, hi, lo;
      logic [N*W-1:0] v;
      if (e - last < N + 1) return;
      last = e;
      t = longint'(tau_inv);
      if (t <= 0) t = 1;
      c = longint'(coupling);
      if (c > 256) c = 256;
      hi = longint'(env_max);
      lo = longint'(env_min);
      nc = nval(mlc);
      mlc = nx(mlc);
      for (int k = 0; k < N; k++) begin
         np = nval(mlp[k]);
         mlp[k] = nx(mlp[k]);
         mix = (nc * c + np * (256 - c)) >>> 8;
         noise = (mix * longint'(sigma)) >>> 7;
         rev = (t * (M - mw[k])) >>> F;
         raw = mw[k] + rev + noise;
         if (raw > hi) raw = hi;
         if (raw < lo) raw = lo;
         mw[k] = raw;
         v[k*W +: W] = W'(raw);
      end
      exp_q.push_back(v);
      due_q.push_back(e + N + 1);
   endtask
   always @(posedge clk) begin
      if (rst) model_reset();
      else if (clk_en) model_trigger(cyc);
      cyc <= cyc + 1;
   end
   int nvalid = 0;
   int nvalid_d = 0;
   bit range_chk = 0, same_chk = 0, diff_chk = 0;
   int range_bad = 0, same_bad = 0;
   bit saw_lo = 0, saw_hi = 0, diff_seen = 0;
   always @(negedge clk) begin
      logic [N*W-1:0] v;
      longint d;
      if (!rst && env_valid_d) nvalid_d++;
      if (!rst && env_valid) begin
         nvalid++;
         if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            v = exp_q.pop_front();
            d = due_q.pop_front();
            check("latency", cyc - 1, d);
            for (int k = 0; k < N; k++) check($sformatf("lane%0d", k), lane(env_flat, k), lane(v, k));
         end
         for (int k = 0; k < N; k++) begin
            if (range_chk && (lane(env_flat, k) < ENV_LO_Q14 || lane(env_flat, k) > ENV_HI_Q14)) range_bad++;
            if (range_chk && lane(env_flat, k) == ENV_LO_Q14) saw_lo = 1;
            if (range_chk && lane(env_flat, k) == ENV_HI_Q14) saw_hi = 1;
            if (same_chk && lane(env_flat, k) != lane(env_flat, 0)) same_bad++;
         end
         if (diff_chk && lane(env_flat, 0) != lane(env_flat, 1)) diff_seen = 1;
      end
   end
   task automatic trigger(input int gap);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", exp_q.size(), 0);
   endtask
   task automatic all_lanes(input string tag, input logic [N*W-1:0] v, input longint exp);
      for (int k = 0; k < N; k++) check($sformatf("%s%0d", tag, k), lane(v, k), exp);
   endtask
   initial begin
      int nv0;
      repeat (3) @(negedge clk);
      all_lanes("rst_lane", env_flat, M);
      all_lanes("rst_lane_d", env_flat_d, M);
      check("rst_valid", env_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy_d", busy_d, 0);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      all_lanes("idle_lane", env_flat, M);
      check("idle_valid_count", nvalid, 0);
      check("idle_busy", busy, 0);
      for (int i = 0; i < 32; i++) begin
         clk_en_d = 1'b1;
         @(negedge clk);
         clk_en_d = 1'b0;
         repeat (11) @(negedge clk);
      end
      check("decim_sweeps", nvalid_d, 2);
      check("decim_overrun", overrun_d, 0);
      all_lanes("decim_lane", env_flat_d, M);
      repeat (64) trigger(12);
      drain();
      check("flat_sweeps", nvalid, 64);
      all_lanes("flat_lane", env_flat, M);
      sigma = 30000;
      tau_inv = 1000;
      coupling = 9'd128;
      range_chk = 1;
      repeat (2000) trigger(10);
      drain();
      range_chk = 0;
      check("range_violations", range_bad, 0);
      check("reached_min", saw_lo, 1);
      check("reached_max", saw_hi, 1);
      check("no_overrun_at_10", overrun, 0);
      env_min = 20000;
      env_max = 10000;
      trigger(12);
      drain();
      all_lanes("inverted_lane", env_flat, 20000);
      env_min = W'(ENV_LO_Q14);
      env_max = W'(ENV_HI_Q14);
      sigma = 100;
      coupling = 9'd300;
      same_chk = 1;
      repeat (20) trigger(12);
      drain();
      same_chk = 0;
      check("coupled_identical", same_bad, 0);
      coupling = 9'd0;
      diff_chk = 1;
      repeat (4) trigger(12);
      drain();
      diff_chk = 0;
      check("private_differs", diff_seen, 1);
      nv0 = nvalid;
      repeat (10) trigger(4);
      drain();
      check("overrun_set", overrun, 1);
      check("overrun_sweeps", nvalid - nv0, 4);
      repeat (20) @(negedge clk);
      check("overrun_held", overrun, 1);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", busy, 1);
      nv0 = nvalid;
      rst = 1'b1;
      @(negedge clk);
      all_lanes("abort_lane", env_flat, M);
      check("abort_busy", busy, 0);
      check("abort_overrun", overrun, 0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
      check("abort_no_valid", nvalid - nv0, 0);
      seed = 16'h0;
      sigma = 3000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) trigger(12);
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
